multicycle_control: RTL

Parametrised multi-cycle successor to the single-cycle combinational decoder. An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and emits per-cycle datapath controls. It waits on a memory ready handshake with a timeout. It owns the N status flag that gates conditional register writes. It sits between the instruction register and the multi-cycle datapath (PC, IR, shared memory, ALU, register file).

---
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, handles the memory
// ready/timeout handshake and owns the N status flag used by conditional writes.
module multicycle_control #(
  parameter int OPW         = 6,
  parameter int FW          = 6,
  parameter int HAS_STATUS  = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  func,
  input  logic           neg_in,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           ir_write,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic [2:0]     state,
  output logic           n_flag_q,
  output logic           illegal,
  output logic           bus_error
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPW-1:0] OP_R   = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW  = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW  = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J   = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_CW  = OPW'(6'b011000);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_r, is_lw, is_sw, is_beq, is_j, is_cw, legal;
  logic             waiting, timeout_hit;
  logic             unused_func;

  // func is consumed by the ALU control downstream, not here
  assign unused_func = ^func;

  assign is_r   = (opcode == OP_R);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);
  assign is_j   = (opcode == OP_J);
  assign is_cw  = (HAS_STATUS != 0) && (opcode == OP_CW);
  assign legal  = is_r | is_lw | is_sw | is_beq | is_j | is_cw;

  assign waiting     = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
  assign timeout_hit = waiting && (MEM_TIMEOUT > 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      cnt_q    <= '0;
      n_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((HAS_STATUS != 0) && (state_q == EXEC) && is_r)
        n_flag_q <= neg_in;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    bus_error     = 1'b0;

    // counter saturates when no timeout is configured so it never wraps
    if (waiting && !timeout_hit)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    else
      cnt_d = '0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (legal) begin
          state_d = EXEC;
        end else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        state_d = FETCH;
        if (is_r) begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = WB;
        end else if (is_lw || is_sw || is_cw) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = is_cw ? WB : MEM;
        end else if (is_beq) begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end else if (is_j) begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
      end
      MEM: begin
        iord = 1'b1;
        if (is_lw) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = WB;
        end else if (is_sw) begin
          mem_write = 1'b1;
          if (mem_ready) state_d = FETCH;
        end else begin
          state_d = FETCH;
        end
      end
      WB: begin
        state_d = FETCH;
        if (is_r) begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end else if (is_lw) begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end else if (is_cw) begin
          reg_write = n_flag_q;
        end
      end
      default: state_d = FETCH;
    endcase

    if (timeout_hit) begin
      bus_error = 1'b1;
      state_d   = FETCH;
    end

    // reset is synchronous, so outputs are forced low for the whole reset cycle
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal       = 1'b0;
      bus_error     = 1'b0;
    end
  end

endmodule
